// File: rtl/pe_responder.sv
// rtl/pe_responder.sv - request-serving PE endpoint that returns local store words as reply packets

// Request queue: small power-of-two FIFO holding {requester, word select}
module pe_responder_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Entry storage; contents are only read while the queue is non-empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push and pop are pre-qualified by the caller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// Endpoint: filter requests by key, queue them, reply with {requester, store[wsel]}
module pe_responder #(
  parameter int N          = 1024,
  parameter int I          = 0,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 4,
  parameter int WSEL_W     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] req_pkt,
  output logic                           req_ready,
  input  logic                           wr_en,
  input  logic [WSEL_W-1:0]              wr_sel,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           resp_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] resp_pkt,
  input  logic                           resp_ready,
  output logic                           err_misroute,
  output logic [ADDR_WIDTH-1:0]          served_cnt
);

  localparam int ENTRY_W = ADDR_WIDTH + WSEL_W;
  localparam logic [ADDR_WIDTH-1:0] NOP_KEY = N[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] OWN_KEY = I[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH+DATA_WIDTH-1:0] NOP_PKT = {NOP_KEY, {DATA_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_WIDTH-1:0] req_key;
  logic [ADDR_WIDTH-1:0] req_src;
  logic [WSEL_W-1:0]     req_wsel;
  logic                  req_accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_dout;

  logic [ADDR_WIDTH-1:0] cur_src;
  logic [WSEL_W-1:0]     cur_wsel;
  logic                  capture;
  logic                  hs_done;

  logic [DATA_WIDTH-1:0] store [MEM_DEPTH];

  assign req_key  = req_pkt[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign req_src  = req_pkt[ADDR_WIDTH-1:0];
  assign req_wsel = req_pkt[ENTRY_W-1:ADDR_WIDTH];

  // Payload bits above the word select carry nothing for this endpoint
  generate
    if (DATA_WIDTH > ENTRY_W) begin : g_spare_payload
      logic unused_payload;
      assign unused_payload = ^req_pkt[DATA_WIDTH-1:ENTRY_W];
    end
  endgenerate

  // A pop never frees a slot for the same cycle's push, so ready is just !full
  assign req_ready  = !fifo_full;
  assign req_accept = req_valid && req_ready;
  assign fifo_push  = req_accept && (req_key == OWN_KEY);

  pe_responder_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  ({req_wsel, req_src}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sticky misroute flag: any consumed key that is neither ours nor the NOP key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_misroute <= 1'b0;
    end else if (req_accept && (req_key != OWN_KEY) && (req_key != NOP_KEY)) begin
      err_misroute <= 1'b1;
    end
  end

  // Local word store, written by the PE side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MEM_DEPTH; k++) store[k] <= '0;
    end else if (wr_en) begin
      store[wr_sel] <= wr_data;
    end
  end

  // Reply FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Reply FSM sequencing: pop in IDLE or on a HOLD handshake, capture in READ
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    hs_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = S_READ;
        end
      end
      S_READ: begin
        capture    = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (resp_ready) begin
          hs_done = 1'b1;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = S_READ;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Popped request fields, held until the reply is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_src  <= '0;
      cur_wsel <= '0;
    end else if (fifo_pop) begin
      {cur_wsel, cur_src} <= fifo_dout;
    end
  end

  // Reply register: store read is sampled pre-write, NOP packet whenever idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_pkt   <= NOP_PKT;
      served_cnt <= '0;
    end else if (capture) begin
      resp_valid <= 1'b1;
      resp_pkt   <= {cur_src, store[cur_wsel]};
    end else if (hs_done) begin
      resp_valid <= 1'b0;
      resp_pkt   <= NOP_PKT;
      served_cnt <= served_cnt + 1'b1;
    end
  end

endmodule
